y_mem_stage: RTL and testbench

//  Memory-access/write-back stage fed directly by yEX: takes ALU result z (address or value) plus rd2 (store data).

---
 rtl/y_mem_pkg.sv | 48 ++++
 rtl/y_mem_stage_if.sv | 15 +
 rtl/y_load_align.sv | 26 ++
 rtl/y_mem_stage.sv | 131 +++++++++++++
 tb/tb_y_mem_stage.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/y_mem_pkg.sv
// Shared types and constants for the y_mem_stage memory/write-back slice.
package y_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  // Request context held for the whole access; lo is the naturally aligned low address.
  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  lo;
    logic [2:0]  f3;
    logic        st;
  } mem_req_t;

  function automatic logic f3_legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return {a[1], 1'b0};
      2'b10:   return 2'b00;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/y_mem_stage_if.sv
// Data-memory req/ack port between y_mem_stage (master) and memory (slave).
interface y_mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
                  input  dm_rdata, dm_ack);
  modport slave  (input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
                  output dm_rdata, dm_ack);
endinterface

// File: rtl/y_load_align.sv
// Load lane select and sign/zero extension of a 32-bit read word.
module y_load_align
  import y_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lo,
  input  logic [2:0]  f3,
  output logic [31:0] val
);
  logic [3:0][7:0] lane;
  logic [7:0]      b;
  logic [15:0]     h;

  always_comb begin
    lane = rdata;
    b    = lane[lo];
    h    = lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_B:    val = {{24{b[7]}}, b};
      F3_BU:   val = {24'b0, b};
      F3_H:    val = {{16{h[15]}}, h};
      F3_HU:   val = {16'b0, h};
      default: val = rdata;
    endcase
  end
endmodule

// File: rtl/y_mem_stage.sv
// Memory-access / write-back stage: IDLE/ACCESS/RESP FSM over a req/ack port.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing alignment.
module y_mem_stage
  import y_mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    funct3,
  input  logic [31:0]   z,
  input  logic [31:0]   rd2,
  y_mem_stage_if.master dm,
  output logic [31:0]   wd,
  output logic          wb_valid,
  output logic          busy,
  output logic          err
);
  localparam logic [3:0] WMAX = 4'(MAX_WAIT);

  state_t      state;
  mem_req_t    req_q;
  logic [3:0]  wcnt;
  logic [31:0] rdata_q;
  logic [31:0] ld_val;

  logic        is_ld, is_st, bad;
  logic [1:0]  a_fix;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  always_comb begin
    is_ld = mem_read & ~mem_write;
    is_st = mem_write & ~mem_read;
    a_fix = align_lo(funct3, z[1:0]);
`ifdef MISALIGN_TRAP_EN
    bad = (mem_read & mem_write) |
          ((is_ld | is_st) & (~f3_legal(is_st, funct3) | misaligned(funct3, z[1:0])));
`else
    bad = (mem_read & mem_write) | ((is_ld | is_st) & ~f3_legal(is_st, funct3));
`endif
    case (funct3[1:0])
      2'b00:   wdata_n = {4{rd2[7:0]}};
      2'b01:   wdata_n = {2{rd2[15:0]}};
      default: wdata_n = rd2;
    endcase
  end

  // Per-lane byte enable from access size and aligned low address.
  for (genvar i = 0; i < 4; i++) begin : g_be
    localparam logic [1:0] L = 2'(i);
    assign be_n[i] = (funct3[1:0] == 2'b10) |
                     ((funct3[1:0] == 2'b01) & (a_fix[1] == L[1])) |
                     ((funct3[1:0] == 2'b00) & (a_fix == L));
  end

  y_load_align u_align (
    .rdata (rdata_q),
    .lo    (req_q.lo),
    .f3    (req_q.f3),
    .val   (ld_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_q       <= '0;
      wcnt        <= '0;
      rdata_q     <= '0;
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_wdata <= '0;
      dm.dm_be    <= '0;
      wd          <= '0;
      wb_valid    <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (bad) begin
              err <= 1'b1;
            end else if (is_ld | is_st) begin
              req_q       <= '{a: z, lo: a_fix, f3: funct3, st: is_st};
              dm.dm_req   <= 1'b1;
              dm.dm_we    <= is_st;
              dm.dm_addr  <= {z[31:2], 2'b00};
              dm.dm_wdata <= wdata_n;
              dm.dm_be    <= be_n;
              busy        <= 1'b1;
              wcnt        <= '0;
              state       <= S_ACCESS;
            end else begin
              wd       <= z;
              wb_valid <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          // An ack on the last allowed cycle still completes the access.
          if (dm.dm_ack) begin
            rdata_q   <= dm.dm_rdata;
            dm.dm_req <= 1'b0;
            state     <= S_RESP;
          end else if (wcnt == WMAX) begin
            dm.dm_req <= 1'b0;
            err       <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        S_RESP: begin
          wd       <= req_q.st ? req_q.a : ld_val;
          wb_valid <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_y_mem_stage.sv
// Scoreboard bench for y_mem_stage: directed ops, memory responder, output monitor.
module tb_y_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] z = '0, rd2 = '0;
  logic [31:0] wd;
  logic        wb_valid, busy, err;

  y_mem_stage_if dmif ();

  y_mem_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .z(z), .rd2(rd2), .dm(dmif), .wd(wd), .wb_valid(wb_valid),
    .busy(busy), .err(err));

  always #5 clk = ~clk;

  typedef struct { logic e; logic [31:0] wd; } exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
                   logic [31:0] rdata; int delay; } rq_t;

  exp_t exp_q[$];
  rq_t  rq_q[$];
  int total = 0, bad = 0;
  int cyc = 0, busy_n = 0, req_n = 0, wb_n = 0, last_out_cyc = 0;
  bit mem_auto = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Output monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_n++;
      if (dmif.dm_req) req_n++;
      if (wb_valid) wb_n++;
      if (wb_valid || err) begin
        last_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output wb_valid=%b err=%b wd=%h", wb_valid, err, wd);
        end else begin
          e = exp_q.pop_front();
          chk("sb_err", {31'b0, err}, {31'b0, e.e});
          chk("sb_wbv", {31'b0, wb_valid}, {31'b0, ~e.e});
          if (!e.e) chk("sb_wd", wd, e.wd);
        end
      end
    end
  end

  // Memory responder: checks the request, acks after 'delay' cycles (-1: never).
  initial begin
    rq_t r;
    int n;
    dmif.dm_ack = 1'b0;
    dmif.dm_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && dmif.dm_req) begin
        if (rq_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req addr=%h", dmif.dm_addr);
          while (dmif.dm_req) @(negedge clk);
        end else begin
          r = rq_q.pop_front();
          chk("req_we", {31'b0, dmif.dm_we}, {31'b0, r.we});
          chk("req_addr", dmif.dm_addr, r.addr);
          chk("req_be", {28'b0, dmif.dm_be}, {28'b0, r.be});
          if (r.we) chk("req_wdata", dmif.dm_wdata, r.wdata);
          if (r.delay >= 0) begin
            repeat (r.delay) @(negedge clk);
            dmif.dm_ack = 1'b1;
            dmif.dm_rdata = r.rdata;
            @(negedge clk);
            dmif.dm_ack = 1'b0;
          end else begin
            n = 1;
            while (n < 100) begin
              @(negedge clk);
              if (dmif.dm_req) n++; else break;
            end
            chk("timeout_req_cycles", n, 16);
          end
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] zz, input logic [31:0] dd, output int s);
    @(negedge clk);
    start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; z = zz; rd2 = dd;
    s = cyc;
    @(negedge clk);
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic push_exp(input logic e, input logic [31:0] v);
    exp_t x;
    x.e = e; x.wd = v;
    exp_q.push_back(x);
  endtask

  task automatic push_rq(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wdat, input logic [31:0] rdat, input int dly);
    rq_t r;
    r.we = we; r.addr = a; r.be = be; r.wdata = wdat; r.rdata = rdat; r.delay = dly;
    rq_q.push_back(r);
  endtask

  // Runs one directed op and checks busy/req cycle counts and drained queues.
  task automatic run(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] zz, input logic [31:0] dd,
                     input int exp_busy, input int exp_req, input int exp_lat);
    int s, b0, r0;
    b0 = busy_n; r0 = req_n;
    issue(rd, wr, f3, zz, dd, s);
    repeat (24) @(negedge clk);
    chk({name, "_busy"}, busy_n - b0, exp_busy);
    chk({name, "_req"}, req_n - r0, exp_req);
    chk({name, "_drain"}, exp_q.size() + rq_q.size(), 0);
    if (exp_lat > 0) chk({name, "_lat"}, last_out_cyc - s, exp_lat);
    chk({name, "_idle"}, {31'b0, busy}, 0);
  endtask

  initial begin
    int w0, s;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, dmif.dm_req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_wbv", {31'b0, wb_valid}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_wd", wd, 0);
    chk("rst_addr", dmif.dm_addr, 0);
    chk("rst_be", {28'b0, dmif.dm_be}, 0);
    rst_n = 1'b1;

    push_exp(0, 32'd42);
    run("alu", 0, 0, 3'b000, 32'd42, 32'd0, 0, 0, 1);

    push_rq(1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 2);
    push_exp(0, 32'h100);
    run("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 4, 3, 5);

    push_rq(0, 32'h100, 4'b1000, 32'h0, 32'h80112233, 0);
    push_exp(0, 32'hFFFFFF80);
    run("lb", 1, 0, 3'b000, 32'h103, 32'h0, 2, 1, 3);

    push_rq(0, 32'h100, 4'b1000, 32'h0, 32'h80112233, 0);
    push_exp(0, 32'h00000080);
    run("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 2, 1, 3);

    push_rq(0, 32'h100, 4'b1100, 32'h0, 32'h80015555, 1);
    push_exp(0, 32'hFFFF8001);
    run("lh", 1, 0, 3'b001, 32'h102, 32'h0, 3, 2, 4);

    push_rq(0, 32'h100, 4'b0011, 32'h0, 32'h1234F00D, 0);
    push_exp(0, 32'h0000F00D);
    run("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 2, 1, 3);

    push_rq(1, 32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0, 1);
    push_exp(0, 32'h101);
    run("sb", 0, 1, 3'b000, 32'h101, 32'h000000A5, 3, 2, 4);

    push_rq(1, 32'h100, 4'b1100, 32'h12341234, 32'h0, 0);
    push_exp(0, 32'h102);
    run("sh", 0, 1, 3'b001, 32'h102, 32'hFFFF1234, 2, 1, 3);

    push_exp(1, 32'h0);
    run("ill_ld_f3", 1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 1);
    push_exp(1, 32'h0);
    run("ill_both", 1, 1, 3'b010, 32'h100, 32'h0, 0, 0, 1);
    push_exp(1, 32'h0);
    run("ill_st_f3", 0, 1, 3'b100, 32'h100, 32'h0, 0, 0, 1);

    push_rq(0, 32'h200, 4'b1111, 32'h0, 32'h0, -1);
    push_exp(1, 32'h0);
    w0 = wb_n;
    run("timeout", 1, 0, 3'b010, 32'h200, 32'h0, 16, 16, 17);
    chk("timeout_no_wb", wb_n - w0, 0);

`ifdef MISALIGN_TRAP_EN
    push_exp(1, 32'h0);
    run("mis_lw", 1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 1);
`else
    push_rq(0, 32'h100, 4'b1111, 32'h0, 32'h11223344, 0);
    push_exp(0, 32'h11223344);
    run("mis_lw", 1, 0, 3'b010, 32'h101, 32'h0, 2, 1, 3);
`endif

    // Reset in the middle of an access; a late ack must not produce write-back.
    mem_auto = 1'b0;
    w0 = wb_n;
    issue(1, 0, 3'b010, 32'h300, 32'h0, s);
    chk("rmid_req_before", {31'b0, dmif.dm_req}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmid_req_after", {31'b0, dmif.dm_req}, 0);
    chk("rmid_busy_after", {31'b0, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    dmif.dm_ack = 1'b1; dmif.dm_rdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    dmif.dm_ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("rmid_no_wb", wb_n - w0, 0);
    mem_auto = 1'b1;

    push_exp(0, 32'd7);
    run("post_rst_alu", 0, 0, 3'b000, 32'd7, 32'd0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d", total);
    $fatal(1, "watchdog");
  end
endmodule
